// File: rtl/demux_pkg.sv
// Shared constants and slot state encoding for the registered 1-to-4 demux.
package demux_pkg;
  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot: load -> out_valid one cycle later; load while draining refills with no bubble.
module demux_slot
  import demux_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [n-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [n-1:0] out_data
);

  slot_state_e  state_q, state_d;
  logic [n-1:0] data_q, data_d;

  // Data only changes on load; it is left in place after a drain.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if (state_q == SLOT_FULL && out_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;

endmodule

// File: rtl/nbit_1to4_demux_reg.sv
// Registered 1-to-4 demux, latency 1; in_ready only drops when the selected slot is full and stalled.
// Optional per-channel saturating accept counters under DEMUX_STATS_EN.
module nbit_1to4_demux_reg
  import demux_pkg::*;
#(
  parameter int n     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel0,
  input  logic             sel1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [n-1:0]     out_data0,
  output logic [n-1:0]     out_data1,
  output logic [n-1:0]     out_data2,
  output logic [n-1:0]     out_data3,
  input  logic [1:0]       stat_sel,
  output logic [CNT_W-1:0] stat_count
);

  logic [CH_IDX_W-1:0] ch_sel;
  logic [NUM_CH-1:0]   load;
  logic [n-1:0]        slot_data [NUM_CH];

  assign ch_sel   = {sel1, sel0};
  // A full slot that is draining this cycle can take a new word.
  assign in_ready = ~out_valid[ch_sel] | out_ready[ch_sel];

  always_comb begin
    load = '0;
    load[ch_sel] = in_valid & in_ready;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.n(n)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (slot_data[k])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (load[k] && (cnt_q[k] != {CNT_W{1'b1}}))
        cnt_d[k] = cnt_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (reset) cnt_q[k] <= '0;
      else       cnt_q[k] <= cnt_d[k];
    end
  end

  assign stat_count = cnt_q[stat_sel];
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_nbit_1to4_demux_reg.sv
// Directed bench for nbit_1to4_demux_reg (n=8, CNT_W=4); stats expectations follow DEMUX_STATS_EN.
module tb_nbit_1to4_demux_reg;
  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel0, sel1;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [N-1:0]  out_data0, out_data1, out_data2, out_data3;
  logic [1:0]    stat_sel;
  logic [CW-1:0] stat_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nbit_1to4_demux_reg #(.n(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel0       (sel0),
    .sel1       (sel1),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
  );

`ifdef DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [N-1:0] d);
    in_valid = v;
    {sel1, sel0} = s;
    in_data = d;
  endtask

  function automatic logic [N-1:0] od(input int k);
    case (k)
      0: od = out_data0;
      1: od = out_data1;
      2: od = out_data2;
      default: od = out_data3;
    endcase
  endfunction

  initial begin
    logic [N-1:0] route_words [4];
    route_words[0] = 8'h11; route_words[1] = 8'h22;
    route_words[2] = 8'h33; route_words[3] = 8'h44;

    // Reset for two cycles with a word offered.
    reset = 1'b1; out_ready = 4'b0000; stat_sel = 2'd0;
    drive(1'b1, 2'd0, 8'h99);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_data0", 16'(out_data0), 16'h0);
    check("rst_data1", 16'(out_data1), 16'h0);
    check("rst_data2", 16'(out_data2), 16'h0);
    check("rst_data3", 16'(out_data3), 16'h0);
    check("rst_in_ready", 16'(in_ready), 16'h1);
    check("rst_stat", 16'(stat_count), 16'h0);
    reset = 1'b0;
    drive(1'b0, 2'd0, 8'h00);

    // Routing: one word per channel on consecutive cycles.
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        check("route_valid", 16'(out_valid), 16'(4'b0001 << (i - 1)));
        check("route_data", 16'(od(i - 1)), 16'(route_words[i - 1]));
      end
      drive(1'b1, 2'(i), route_words[i]);
      #1 check("route_in_ready", 16'(in_ready), 16'h1);
      @(negedge clk);
    end
    check("route_valid3", 16'(out_valid), 16'h8);
    check("route_data3", 16'(out_data3), 16'h44);
    drive(1'b0, 2'd0, 8'h00);
    stat_sel = 2'd2;
    @(negedge clk);
    check("drained_valid", 16'(out_valid), 16'h0);
    check("hold_data3", 16'(out_data3), 16'h44);
    check("stat_ch2_one", 16'(stat_count), STATS ? 16'h1 : 16'h0);

    // Backpressure isolation on ch2.
    out_ready = 4'b1011;
    drive(1'b1, 2'd2, 8'hA0);
    #1 check("bp_in_ready_a0", 16'(in_ready), 16'h1);
    @(negedge clk);
    check("bp_valid_a0", 16'(out_valid), 16'h4);
    check("bp_data_a0", 16'(out_data2), 16'hA0);
    drive(1'b1, 2'd2, 8'hA1);
    #1 check("bp_in_ready_a1", 16'(in_ready), 16'h0);
    @(negedge clk);
    check("bp_stall_valid", 16'(out_valid), 16'h4);
    check("bp_stall_data", 16'(out_data2), 16'hA0);
    drive(1'b1, 2'd1, 8'hB0);
    #1 check("bp_in_ready_b0", 16'(in_ready), 16'h1);
    @(negedge clk);
    check("bp_valid_b0", 16'(out_valid), 16'h6);
    check("bp_data_b0", 16'(out_data1), 16'hB0);
    check("bp_data_a0_kept", 16'(out_data2), 16'hA0);
    drive(1'b1, 2'd2, 8'hA1);
    out_ready = 4'b1111;
    #1 check("bp_in_ready_release", 16'(in_ready), 16'h1);
    @(negedge clk);
    check("bp_valid_a1", 16'(out_valid), 16'h4);
    check("bp_data_a1", 16'(out_data2), 16'hA1);
    drive(1'b0, 2'd0, 8'h00);
    @(negedge clk);
    check("bp_drained", 16'(out_valid), 16'h0);

    // Simultaneous drain and refill on ch0.
    out_ready = 4'b0000;
    drive(1'b1, 2'd0, 8'h5A);
    @(negedge clk);
    check("dr_valid_5a", 16'(out_valid), 16'h1);
    check("dr_data_5a", 16'(out_data0), 16'h5A);
    out_ready = 4'b0001;
    drive(1'b1, 2'd0, 8'hC3);
    #1 check("dr_in_ready", 16'(in_ready), 16'h1);
    @(negedge clk);
    check("dr_valid_c3", 16'(out_valid), 16'h1);
    check("dr_data_c3", 16'(out_data0), 16'hC3);

    // sel changes with in_valid low do nothing; ready on empty slots is ignored.
    drive(1'b0, 2'd3, 8'hEE);
    @(negedge clk);
    check("idle_valid", 16'(out_valid), 16'h0);
    check("idle_data3", 16'(out_data3), 16'h44);

    // Reset mid-operation discards a held word.
    out_ready = 4'b0000;
    drive(1'b1, 2'd3, 8'h7E);
    @(negedge clk);
    check("mr_valid_7e", 16'(out_valid), 16'h8);
    drive(1'b0, 2'd3, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_valid_after", 16'(out_valid), 16'h0);
    check("mr_data3_after", 16'(out_data3), 16'h0);
    #1 check("mr_in_ready", 16'(in_ready), 16'h1);
    out_ready = 4'b1111;
    @(negedge clk);
    check("mr_never_delivered", 16'(out_valid), 16'h0);

    // Counter saturation: 20 back-to-back words to ch1.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'd1, 8'(i));
      @(negedge clk);
    end
    drive(1'b0, 2'd0, 8'h00);
    check("sat_last_data1", 16'(out_data1), 16'h13);
    for (int k = 0; k < 4; k++) begin
      stat_sel = 2'(k);
      #1 check("stat_read", 16'(stat_count), (STATS && k == 1) ? 16'hF : 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
